// File: rtl/booleanfpga_sevenseg_mux_if.sv
// Load bus for the seven-segment driver: one frame of digit data, decimal
// points and blanking mask, transferred with a valid/ready handshake.
interface booleanfpga_sevenseg_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    data_valid;
    logic                    data_ready;

    modport master (
        output digit_data,
        output dp_in,
        output blank_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  digit_data,
        input  dp_in,
        input  blank_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/booleanfpga_sevenseg_mux.sv
// Multiplexed seven-segment driver: banked cathodes, double-buffered tear-free
// loads, per-digit blanking, anti-ghosting guard time and PWM brightness.
module booleanfpga_sevenseg_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int BANKS        = 2,
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000,
    parameter int BRIGHT_W     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    booleanfpga_sevenseg_mux_if.slave         load,
    input  logic [BRIGHT_W-1:0]               brightness,
    output logic                              frame_start,
    output logic [NUM_DIGITS-1:0]             AN,
    output logic [8*BANKS-1:0]                cat
);

    localparam int DPB    = NUM_DIGITS / BANKS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(DIGIT_CYCLES);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] GUARD_L   = SLOT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Segment decode, {CG..CA}, active low.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;

    logic [4*NUM_DIGITS-1:0] pend_data, act_data;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic                    pend_full;

    logic                    slot_end, frame_end, capture;
    logic                    on_p0;
    logic [NUM_DIGITS-1:0]   an_p0;
    logic [8*BANKS-1:0]      cat_p0;
    logic                    wrap_p1;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (digit_idx == IDX_LAST);
    assign capture   = load.data_valid && !pend_full;
    assign load.data_ready = !pend_full;

    // Scan timebase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (slot_end) begin
                slot_cnt  <= '0;
                digit_idx <= frame_end ? '0 : digit_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Capture only while empty and commit only while full, so the two never
    // collide: data captured on a wrap cycle waits for the following wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_full  <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
        end else begin
            if (capture) begin
                pend_data  <= load.digit_data;
                pend_dp    <= load.dp_in;
                pend_blank <= load.blank_in;
            end
            if (frame_end && pend_full) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (capture) begin
                pend_full <= 1'b1;
            end else if (frame_end) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Stage p0: lit decision and cathode pattern from the current scan state
    assign on_p0 = (slot_cnt >= GUARD_L) && (pwm_cnt <= brightness);

    always_comb begin
        an_p0  = '1;
        cat_p0 = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (on_p0 && (digit_idx == IDX_W'(i)) && !act_blank[i]) begin
                an_p0[i]               = 1'b0;
                cat_p0[8*(i/DPB) +: 8] = {~act_dp[i], seg7(act_data[4*i +: 4])};
            end
        end
    end

    // Stage p1: registered pins; frame_start lags the index wrap by one more cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AN          <= '1;
            cat         <= '1;
            wrap_p1     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            AN          <= an_p0;
            cat         <= cat_p0;
            wrap_p1     <= frame_end;
            frame_start <= wrap_p1;
        end
    end

endmodule

// File: tb/tb_booleanfpga_sevenseg_mux.sv
// Bench for booleanfpga_sevenseg_mux: time-indexed reference model feeding a
// per-cycle scoreboard, plus directed checks of the documented display values.
module tb_booleanfpga_sevenseg_mux;

    localparam int ND = 8;
    localparam int BK = 2;
    localparam int DC = 8;
    localparam int GC = 2;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [BW-1:0]   brightness;
    logic            frame_start;
    logic [ND-1:0]   AN;
    logic [8*BK-1:0] cat;

    booleanfpga_sevenseg_mux_if #(.NUM_DIGITS(ND)) bus ();

    booleanfpga_sevenseg_mux #(
        .NUM_DIGITS(ND), .BANKS(BK), .DIGIT_CYCLES(DC),
        .GUARD_CYCLES(GC), .BRIGHT_W(BW)
    ) dut (
        .clk(clk), .reset(reset), .load(bus), .brightness(brightness),
        .frame_start(frame_start), .AN(AN), .cat(cat)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference model: m_t is the number of clock edges since reset release.
    int          m_t;
    logic [31:0] m_pd, m_ad;
    logic [7:0]  m_pdp, m_adp, m_pb, m_ab;
    bit          m_full, m_wrap;
    logic [25:0] sb[$];

    initial forever begin : model
        int slot, idx, pwm;
        logic [7:0]  an_e;
        logic [15:0] cat_e;
        logic        fs_e;
        bit          wrap, cap;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_t = 0; m_pd = '0; m_ad = '0; m_pdp = '0; m_adp = '0;
            m_pb = '1; m_ab = '1; m_full = 0; m_wrap = 0;
            sb.delete();
        end else begin
            slot = m_t % DC;
            idx  = (m_t / DC) % ND;
            pwm  = m_t % (1 << BW);
            an_e  = '1;
            cat_e = '1;
            if (slot >= GC && pwm <= int'(brightness) && !m_ab[idx]) begin
                an_e[idx] = 1'b0;
                cat_e[8*(idx/(ND/BK)) +: 8] = {~m_adp[idx], seg(m_ad[4*idx +: 4])};
            end
            fs_e   = m_wrap;
            wrap   = (m_t % (DC*ND)) == (DC*ND - 1);
            m_wrap = wrap;
            cap    = bus.data_valid && !m_full;
            if (wrap && m_full) begin
                m_ad = m_pd; m_adp = m_pdp; m_ab = m_pb; m_full = 0;
            end
            if (cap) begin
                m_pd = bus.digit_data; m_pdp = bus.dp_in; m_pb = bus.blank_in; m_full = 1;
            end
            sb.push_back({an_e, cat_e, fs_e, !m_full});
            m_t++;
        end
    end

    initial forever begin : scoreboard
        logic [25:0] e;
        @(posedge clk);
        #1;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            check("cycle", {6'b0, AN, cat, frame_start, bus.data_ready}, {6'b0, e});
        end
    end

    task automatic goto(input int t);
        int guard = 0;
        while (m_t < t && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (m_t != t) begin
            n_total++;
            n_fail++;
            $error("FAIL sync: cycle %0d target %0d", m_t, t);
        end
    endtask

    int lit_cnt[ND];
    task automatic count_lit();
        for (int i = 0; i < ND; i++) lit_cnt[i] = 0;
        repeat (DC*ND) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < ND; i++) if (!AN[i]) lit_cnt[i]++;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        bus.data_valid = v;
        bus.digit_data = d;
        bus.dp_in      = dp;
        bus.blank_in   = bl;
    endtask

    task automatic wait_fs();
        int guard = 0;
        while (!frame_start && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        reset = 1'b1;
        brightness = '0;
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_an", 32'(AN), 32'hFF);
        check("rst_cat", 32'(cat), 32'hFFFF);
        check("rst_fs", 32'(frame_start), 32'h0);
        check("rst_ready", 32'(bus.data_ready), 32'h1);

        // First load: captured on the first edge after release.
        drive(1'b1, 32'h7654_3210, 8'h00, 8'h00);
        brightness = 4'hF;
        reset = 1'b0;
        goto(1);
        check("ready_drop", 32'(bus.data_ready), 32'h0);
        drive(1'b0, 32'h7654_3210, 8'h00, 8'h00);
        goto(63);
        check("ready_hold", 32'(bus.data_ready), 32'h0);
        goto(64);
        check("ready_rise", 32'(bus.data_ready), 32'h1);
        wait_fs();
        check("first_fs_cycle", 32'(m_t), 32'd65);

        goto(68);
        check("d0_an", 32'(AN), 32'hFE);
        check("d0_cat", 32'(cat), 32'hFFC0);
        goto(100);
        check("d4_an", 32'(AN), 32'hEF);
        check("d4_cat", 32'(cat), 32'h99FF);

        count_lit();
        for (int i = 0; i < ND; i++) check($sformatf("lit6_d%0d", i), 32'(lit_cnt[i]), 32'd6);

        // Load in digit 3 slot of the frame starting at 192, then an ignored load.
        goto(218);
        drive(1'b1, 32'h89AB_CDEF, 8'h00, 8'h00);
        goto(219);
        check("ready_cap2", 32'(bus.data_ready), 32'h0);
        drive(1'b1, 32'hFFFF_FFFF, 8'h00, 8'h00);
        goto(222);
        drive(1'b0, 32'hFFFF_FFFF, 8'h00, 8'h00);
        goto(228);
        check("old_d4_cat", 32'(cat), 32'h99FF);
        goto(260);
        check("new_d0_an", 32'(AN), 32'hFE);
        check("new_d0_cat", 32'(cat), 32'hFF8E);
        goto(292);
        check("new_d4_cat", 32'(cat), 32'h83FF);

        brightness = 4'h0;
        goto(294);
        count_lit();
        total = 0;
        for (int i = 0; i < ND; i++) total += lit_cnt[i];
        check("dark_b0", 32'(total), 32'd0);

        brightness = 4'h3;
        goto(360);
        count_lit();
        check("b3_d0", 32'(lit_cnt[0]), 32'd2);
        check("b3_d1", 32'(lit_cnt[1]), 32'd0);

        // Blank digit 1, light DP on digit 0; commits at the wrap into 448.
        brightness = 4'hF;
        drive(1'b1, 32'h0000_0000, 8'h01, 8'h02);
        goto(425);
        drive(1'b0, 32'h0000_0000, 8'h01, 8'h02);
        goto(452);
        check("dp_d0_an", 32'(AN), 32'hFE);
        check("dp_d0_cat", 32'(cat), 32'hFF40);
        goto(460);
        check("blank_d1_an", 32'(AN), 32'hFF);
        check("blank_d1_cat", 32'(cat), 32'hFFFF);
        goto(468);
        check("pre_rst_an", 32'(AN), 32'hFB);

        // Pending data captured, then lost to a mid-slot reset.
        drive(1'b1, 32'h1111_1111, 8'h00, 8'h00);
        goto(469);
        check("ready_cap3", 32'(bus.data_ready), 32'h0);
        drive(1'b0, 32'h1111_1111, 8'h00, 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_an", 32'(AN), 32'hFF);
        check("arst_cat", 32'(cat), 32'hFFFF);
        check("arst_fs", 32'(frame_start), 32'h0);
        check("arst_ready", 32'(bus.data_ready), 32'h1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        wait_fs();
        check("fs_after_rst", 32'(m_t), 32'd65);
        goto(68);
        check("dark_after_rst", 32'(AN), 32'hFF);
        goto(72);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
